// File: rtl/traffic_gen_rr.sv
// traffic_gen_rr: start-triggered burst generator and round-robin checker for an N-channel FIFO switch.
// Ports: i_clk clock; i_rst_n async active-low reset; i_start run trigger (IDLE/DONE only);
//   i_fifo_full almost-full per input FIFO; i_fifo_empty empty per output FIFO;
//   i_data_out_flat output FIFO read data, channel c at [c*W +: W];
//   o_fifo_in_flat input FIFO write data (same packing); o_push / o_pop per-channel strobes;
//   o_busy PUSH/POP/GAP; o_done DONE; o_timeout / o_dest_err sticky flags;
//   o_push_count / o_pop_count per-run totals.
module traffic_gen_rr #(
    parameter int          N_CH    = 4,
    parameter int          DEST_W  = 2,
    parameter int          DATA_W  = 8,
    parameter int          BURST   = 8,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          GAP     = 1,
    parameter int          TIMEOUT = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [N_CH-1:0]                   i_fifo_full,
    input  logic [N_CH-1:0]                   i_fifo_empty,
    input  logic [N_CH*(DEST_W+DATA_W)-1:0]   i_data_out_flat,
    output logic [N_CH*(DEST_W+DATA_W)-1:0]   o_fifo_in_flat,
    output logic [N_CH-1:0]                   o_push,
    output logic [N_CH-1:0]                   o_pop,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_timeout,
    output logic                              o_dest_err,
    output logic [15:0]                       o_push_count,
    output logic [15:0]                       o_pop_count
);
    localparam int W  = DEST_W + DATA_W;
    localparam int PW = $clog2(N_CH);
    localparam logic [2:0] S_IDLE = 3'd0, S_PUSH = 3'd1, S_POP = 3'd2, S_GAP = 3'd3, S_DONE = 3'd4;

    logic [2:0]    r_state, w_nxt;
    logic [7:0]    r_k [N_CH];
    logic [15:0]   r_lfsr [N_CH];
    logic [PW-1:0] r_ptr, r_chk_ch, w_ptr_nx;
    logic [3:0]    r_gcnt;
    logic [15:0]   r_idle;
    logic          r_chk_v;
    logic [N_CH-1:0] w_go;
    logic          w_last, w_launch, w_hit, w_fin, w_to;

    function automatic logic [15:0] f_seed(input int c);
        logic [15:0] s;
        s = SEED ^ 16'(c);
        return (s == 16'h0) ? 16'h0001 : s;
    endfunction

    always_comb begin
        w_last = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            w_go[c] = (r_k[c] < 8'(BURST)) && !i_fifo_full[c];
            // PUSH ends on the edge that registers the final push of every channel
            w_last  = w_last && ((r_k[c] + 8'(w_go[c])) == 8'(BURST));
        end
        w_launch = i_start && (r_state == S_IDLE || r_state == S_DONE);
        w_hit    = !i_fifo_empty[r_ptr];
        w_fin    = o_pop_count == 16'(N_CH * BURST);
        w_to     = r_idle == 16'(TIMEOUT);
        w_ptr_nx = (r_ptr == PW'(N_CH - 1)) ? '0 : r_ptr + 1'b1;
        w_nxt    = w_launch                            ? S_PUSH :
                   (r_state == S_PUSH && w_last)       ? S_POP  :
                   (r_state == S_POP)                  ? ((w_fin || w_to) ? S_DONE : (w_hit ? S_GAP : S_POP)) :
                   (r_state == S_GAP && r_gcnt == 4'(GAP)) ? S_POP :
                   r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_chk_ch       <= '0;
            r_chk_v        <= 1'b0;
            r_gcnt         <= '0;
            r_idle         <= '0;
            o_fifo_in_flat <= '0;
            o_push         <= '0;
            o_pop          <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_timeout      <= 1'b0;
            o_dest_err     <= 1'b0;
            o_push_count   <= '0;
            o_pop_count    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_k[c]    <= '0;
                r_lfsr[c] <= f_seed(c);
            end
        end else begin
            r_state <= w_nxt;
            o_busy  <= (w_nxt == S_PUSH) || (w_nxt == S_POP) || (w_nxt == S_GAP);
            o_done  <= w_nxt == S_DONE;
            o_push  <= '0;
            o_pop   <= '0;
            // read data for a pop is sampled one cycle after the pop strobe is visible
            r_chk_v <= |o_pop;
            if (r_chk_v && i_data_out_flat[r_chk_ch*W + DATA_W +: DEST_W] != DEST_W'(r_chk_ch))
                o_dest_err <= 1'b1;
            if (w_launch) begin
                o_push_count <= '0;
                o_pop_count  <= '0;
                o_timeout    <= 1'b0;
                o_dest_err   <= 1'b0;
                r_idle       <= '0;
                r_ptr        <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    r_k[c]    <= '0;
                    r_lfsr[c] <= f_seed(c);
                end
            end else if (r_state == S_PUSH) begin
                for (int c = 0; c < N_CH; c++)
                    if (w_go[c]) begin
                        o_push[c]                <= 1'b1;
                        o_fifo_in_flat[c*W +: W] <= {DEST_W'(DEST_W'(r_k[c]) % N_CH), r_lfsr[c][DATA_W-1:0]};
                        r_k[c]                   <= r_k[c] + 8'd1;
                        r_lfsr[c]                <= {r_lfsr[c][14:0], r_lfsr[c][15] ^ r_lfsr[c][13] ^ r_lfsr[c][12] ^ r_lfsr[c][10]};
                    end
                o_push_count <= o_push_count + 16'($countones(w_go));
                r_ptr        <= '0;
            end else if (r_state == S_POP) begin
                if (!w_fin && w_to)
                    o_timeout <= 1'b1;
                else if (!w_fin && w_hit) begin
                    o_pop[r_ptr] <= 1'b1;
                    o_pop_count  <= o_pop_count + 16'd1;
                    r_idle       <= '0;
                    r_gcnt       <= '0;
                    r_chk_ch     <= r_ptr;
                end else if (!w_fin) begin
                    r_ptr  <= w_ptr_nx;
                    r_idle <= r_idle + 16'd1;
                end
            end else if (r_state == S_GAP) begin
                if (r_gcnt == 4'(GAP))
                    r_ptr <= w_ptr_nx;
                else
                    r_gcnt <= r_gcnt + 4'd1;
            end
        end
    end
endmodule

// File: doc/traffic_gen_rr.md
Name: traffic_gen_rr

Overview:
- Synthesizable, parametrised traffic generator and monitor for an N-channel FIFO switch. Replaces hand-timed stimulus with a start-triggered engine.
- Phase 1: pushes a burst of tagged words {dest, payload} into every input FIFO, honouring per-channel full.
- Phase 2: drains the output FIFOs with round-robin single-cycle pops and checks each returned word's dest tag against the channel it was popped from.
- Sits between the switch's input/output FIFO banks and the bench or on-chip BIST control.

Parameters:
- N_CH, 4, number of input and output channels (2..8).
- DEST_W, 2, dest-tag width; must be >= clog2(N_CH).
- DATA_W, 8, payload width (1..16).
- BURST, 8, words pushed per input channel per run (1..255).
- SEED, 16'hACE1, LFSR seed; channel c is seeded with SEED ^ c. A resulting zero seed is replaced by 16'h0001.
- GAP, 1, idle cycles after each pop before advancing the pointer (0..15).
- TIMEOUT, 64, consecutive cycles without a pop in the pop phase before the run aborts.

Ports (W = DEST_W + DATA_W):
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- fifo_full  in  N_CH  almost-full per input FIFO; must carry at least 1 word of margin.
- fifo_empty  in  N_CH  empty flag per output FIFO.
- data_out_flat  in  N_CH*W  output FIFO read data; channel c occupies bits [c*W +: W].
- fifo_in_flat  out  N_CH*W  write data to the input FIFOs, same packing.
- push  out  N_CH  per-channel push strobe.
- pop  out  N_CH  per-channel pop strobe; at most one bit set per cycle.
- busy  out  1  high while the FSM is in PUSH, POP or GAP.
- done  out  1  high in DONE; held until the next start.
- timeout  out  1  sticky; set when the pop phase aborts.
- dest_err  out  1  sticky; set on any dest-tag mismatch.
- push_count  out  16  total accepted pushes in the current run.
- pop_count  out  16  total pops in the current run.

Behaviour:
- Reset (asynchronous assert, synchronous release on the next clk):
  - All outputs = 0.
  - FSM = IDLE.
  - k_c = 0 for every channel; LFSRs loaded with their seeds.
- All outputs are registered.
- FSM states: IDLE, PUSH, POP, GAP, DONE.
- IDLE:
  - start moves to PUSH.
  - Entry clears push_count, pop_count, timeout, dest_err and every k_c; LFSRs are re-seeded.
- DONE:
  - start moves to PUSH, with the same clears as IDLE.
  - start seen in any other state is ignored.
- PUSH, on each edge for each channel c:
  - push[c] <= (k_c < BURST) && !fifo_full[c].
  - On that same condition, the c slice of fifo_in_flat <= {k_c[DEST_W-1:0] mod N_CH, lfsr_c[DATA_W-1:0]}. Then k_c increments, lfsr_c advances, and push_count increments by the number of pushing channels that cycle.
  - A channel that is full holds its k_c and lfsr_c and drives push[c] = 0. The other channels proceed independently.
  - When every k_c == BURST, the FSM moves to POP with ptr = 0. The last push pulse is still driven on that transition edge.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left. Feedback bit = b15^b13^b12^b10.
- POP:
  - If !fifo_empty[ptr]: pop[ptr] = 1 for exactly one cycle, pop_count increments, the idle counter is cleared, and the FSM moves to GAP.
  - Otherwise ptr <= (ptr+1) mod N_CH, the idle counter increments, and the FSM stays in POP.
- GAP:
  - Holds GAP cycles with pop = 0, then ptr <= (ptr+1) mod N_CH and the FSM returns to POP.
  - GAP = 0 returns to POP on the next edge.
- Pop-phase exit conditions:
  - pop_count == N_CH*BURST moves to DONE.
  - Idle counter == TIMEOUT sets timeout and moves to DONE.
- Check: read data is valid the cycle after pop[c]. On that cycle, if dest field != c, dest_err is set. dest_err does not abort the run.
- busy and done are mutually exclusive.
- Reset asserted mid-run forces the full reset state immediately. No partial push or pop completes.
- Simultaneous full deassert and BURST completion on the same channel: the final push is issued and the channel is then complete.

Test Plan:
- Defaults, FIFOs never full, loopback model routing each word by its tag -> 8 push cycles with push=4'b1111, push_count=32. Then 32 pops, each followed by 1 gap cycle; done=1, dest_err=0, timeout=0.
- fifo_full[2] held high for 5 cycles during PUSH -> push[2] low for those 5 cycles. Channels 0, 1 and 3 finish first; channel 2 finishes 5 cycles later; push_count=32.
- Channel 0 first word with SEED=16'hACE1 -> fifo_in_flat[9:0]={2'b00, 8'hE1}. Channel 1 first word -> {2'b00, 8'hE0}.
- Output FIFO 3 model returns dest=2'b01 -> dest_err set the cycle after pop[3]; the run still reaches done.
- Output FIFOs all empty after PUSH -> after 64 idle cycles timeout=1, done=1, pop_count=0.
- Reset driven low mid-POP, then start issued after release -> all outputs 0 asynchronously. A fresh run completes with push_count=32 and the same first words as the initial run.
